// File: rtl/bpu_pkg.sv
// Shared constants and index hashing for the gshare branch predictor.
// All helpers are constant functions so they can size parameters and localparams.
package bpu_pkg;

    function automatic int unsigned CTR_WEAK_NT(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned CTR_MAX(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // pcWord is the PC already shifted right by two, so the byte offset never reaches the hash.
    function automatic logic [31:0] bpu_idx(input logic [31:0] pcWord,
                                            input logic [31:0] hist,
                                            input int unsigned idxWidth);
        logic [31:0] mask;
        mask = (idxWidth >= 32) ? '1 : ((32'd1 << idxWidth) - 32'd1);
        return (pcWord ^ hist) & mask;
    endfunction

endpackage

// File: rtl/satcount_n.sv
// One saturating up/down counter: counts up when dir_i is set, down otherwise, only while en_i.
// It never wraps past 0 or past the all-ones maximum.
module satcount_n
    import bpu_pkg::*;
#(
    parameter int unsigned           WIDTH     = 2,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(CTR_MAX(WIDTH));

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (dir_i && (count_q != MAX_VAL)) begin
                count_d = count_q + 1'b1;
            end else if (!dir_i && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/gshare_bpu.sv
// gshare direction predictor: PC XOR speculative global history selects a saturating counter.
// Predicts combinationally at fetch, trains and repairs history from the execute stage.
module gshare_bpu
    import bpu_pkg::*;
#(
    parameter int GHR_WIDTH  = 10,
    parameter int PC_WIDTH   = 32,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_valid_f,
    input  logic [PC_WIDTH-1:0]   pred_pc_f,
    output logic                  pred_taken_f,
    output logic [GHR_WIDTH-1:0]  pred_ghr_f,
    input  logic                  upd_valid_e,
    input  logic [PC_WIDTH-1:0]   upd_pc_e,
    input  logic [GHR_WIDTH-1:0]  upd_ghr_e,
    input  logic                  upd_taken_e,
    input  logic                  upd_mispred_e,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispreds
);

    localparam int               DEPTH   = 1 << GHR_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(CTR_WEAK_NT(CTR_WIDTH));

    logic [GHR_WIDTH-1:0]  ghrSpec_q, ghrSpec_d;
    logic [STAT_WIDTH-1:0] branches_q, mispreds_q;
    logic [GHR_WIDTH-1:0]  predIdx, updIdx;
    logic [CTR_WIDTH-1:0]  ctrs [DEPTH];
    logic                  recover;

    assign predIdx = GHR_WIDTH'(bpu_idx(32'(pred_pc_f >> 2), 32'(ghrSpec_q), GHR_WIDTH));
    assign updIdx  = GHR_WIDTH'(bpu_idx(32'(upd_pc_e >> 2), 32'(upd_ghr_e), GHR_WIDTH));
    assign recover = upd_valid_e && upd_mispred_e;

    // Only the entry addressed by the update port sees its enable; all others hold.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        satcount_n #(
            .WIDTH     (CTR_WIDTH),
            .RESET_VAL (CTR_RESET)
        ) u_ctr (
            .clk     (clk),
            .reset   (reset),
            .en_i    (upd_valid_e && (updIdx == GHR_WIDTH'(i))),
            .dir_i   (upd_taken_e),
            .count_o (ctrs[i])
        );
    end

    assign pred_taken_f = ctrs[predIdx][CTR_WIDTH-1];
    assign pred_ghr_f   = ghrSpec_q;

    // A mispredict rebuilds history from the branch's own snapshot; the fetch shift that cycle is flushed.
    always_comb begin
        ghrSpec_d = ghrSpec_q;
        if (recover) begin
            ghrSpec_d = {upd_ghr_e[GHR_WIDTH-2:0], upd_taken_e};
        end else if (pred_valid_f) begin
            ghrSpec_d = {ghrSpec_q[GHR_WIDTH-2:0], pred_taken_f};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghrSpec_q  <= '0;
            branches_q <= '0;
            mispreds_q <= '0;
        end else begin
            ghrSpec_q <= ghrSpec_d;
            if (upd_valid_e && (branches_q != '1)) begin
                branches_q <= branches_q + 1'b1;
            end
            if (recover && (mispreds_q != '1)) begin
                mispreds_q <= mispreds_q + 1'b1;
            end
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispreds = mispreds_q;

endmodule

// File: tb/tb_gshare_bpu.sv
// Bench for gshare_bpu (GHR_WIDTH=4, CTR_WIDTH=2) against a plain integer-array model.
// A second instance with 2-bit statistics shares all inputs to exercise stat saturation.
module tb_gshare_bpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        predValid = 1'b0;
    logic [31:0] predPc = '0;
    logic        updValid = 1'b0;
    logic [31:0] updPc = '0;
    logic [3:0]  updGhr = '0;
    logic        updTaken = 1'b0;
    logic        updMispred = 1'b0;

    logic        predTaken, predTakenS;
    logic [3:0]  predGhr, predGhrS;
    logic [31:0] statBr, statMp;
    logic [1:0]  statBrS, statMpS;

    int total = 0;
    int bad = 0;

    int mdl [16];
    int mGhr = 0;
    int mBr = 0;
    int mMp = 0;

    always #5 clk = ~clk;

    gshare_bpu #(.GHR_WIDTH(4), .PC_WIDTH(32), .CTR_WIDTH(2), .STAT_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .pred_valid_f(predValid), .pred_pc_f(predPc),
        .pred_taken_f(predTaken), .pred_ghr_f(predGhr),
        .upd_valid_e(updValid), .upd_pc_e(updPc), .upd_ghr_e(updGhr),
        .upd_taken_e(updTaken), .upd_mispred_e(updMispred),
        .stat_branches(statBr), .stat_mispreds(statMp)
    );

    gshare_bpu #(.GHR_WIDTH(4), .PC_WIDTH(32), .CTR_WIDTH(2), .STAT_WIDTH(2)) dutS (
        .clk(clk), .reset(reset),
        .pred_valid_f(predValid), .pred_pc_f(predPc),
        .pred_taken_f(predTakenS), .pred_ghr_f(predGhrS),
        .upd_valid_e(updValid), .upd_pc_e(updPc), .upd_ghr_e(updGhr),
        .upd_taken_e(updTaken), .upd_mispred_e(updMispred),
        .stat_branches(statBrS), .stat_mispreds(statMpS)
    );

    function automatic int mIdx(input logic [31:0] pc, input int h);
        return (int'(pc >> 2) ^ h) & 15;
    endfunction

    function automatic int expPred();
        return (mdl[mIdx(predPc, mGhr)] >= 2) ? 1 : 0;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic [3:0] ug, input logic ut,
                         input logic um, input logic rst);
        @(negedge clk);
        predValid  = pv;
        predPc     = ppc;
        updValid   = uv;
        updPc      = upc;
        updGhr     = ug;
        updTaken   = ut;
        updMispred = um;
        reset      = rst;
        #1;
    endtask

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic tick();
        int pt;
        int newG;
        int i;
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 16; k++) mdl[k] = 1;
            mGhr = 0;
            mBr  = 0;
            mMp  = 0;
        end else begin
            pt   = expPred();
            newG = mGhr;
            if (predValid) newG = ((mGhr << 1) | pt) & 15;
            if (updValid && updMispred) newG = ((int'(updGhr) << 1) | int'(updTaken)) & 15;
            if (updValid) begin
                i = mIdx(updPc, int'(updGhr));
                if (updTaken) mdl[i] = (mdl[i] == 3) ? 3 : mdl[i] + 1;
                else          mdl[i] = (mdl[i] == 0) ? 0 : mdl[i] - 1;
                mBr++;
                if (updMispred) mMp++;
            end
            mGhr = newG;
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        total++;
        if (predTaken !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_pred: got %0b expected 0", predTaken);
        end
        total++;
        if (predGhr !== 4'h0) begin
            bad++; $display("[TB] FAIL reset_ghr: got %0h expected 0", predGhr);
        end
        total++;
        if (statBr !== 32'd0 || statMp !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", statBr, statMp);
        end
        tick();
        drive(1'b0, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (predGhr !== 4'h0) begin
            bad++; $display("[TB] FAIL reset_next_ghr: got %0h expected 0", predGhr);
        end
        tick();
    endtask

    task automatic test_train_saturate();
        logic [8:0] outcomes;
        outcomes = 9'b110000111;
        for (int n = 0; n < 9; n++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, outcomes[n], 1'b0, 1'b0);
            total++;
            if (predTaken !== expPred()) begin
                bad++; $display("[TB] FAIL train_step%0d: got %0b expected %0d", n, predTaken, expPred());
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (predTaken !== 1'b1) begin
            bad++; $display("[TB] FAIL train_final: got %0b expected 1", predTaken);
        end
        tick();
    endtask

    task automatic test_history();
        drive(1'b0, 32'h0, 1'b1, 32'h100, 4'b0010, 1'b1, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            if (n == 0) begin
                total++;
                if (predGhr !== 4'b0101) begin
                    bad++; $display("[TB] FAIL hist_start: got %0b expected 0101", predGhr);
                end
            end
            total++;
            if (predTaken !== expPred() || predGhr !== 4'(mGhr)) begin
                bad++; $display("[TB] FAIL hist_step%0d: got %0b/%0b expected %0d/%0b",
                                n, predTaken, predGhr, expPred(), 4'(mGhr));
            end
            tick();
        end
        drive(1'b0, 32'h14, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (predGhr !== 4'(mGhr)) begin
            bad++; $display("[TB] FAIL hist_end: got %0b expected %0b", predGhr, 4'(mGhr));
        end
        tick();
    endtask

    task automatic test_recovery_priority();
        drive(1'b1, 32'h40, 1'b1, 32'h200, 4'b0011, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (predGhr !== 4'b0111) begin
            bad++; $display("[TB] FAIL recover_ghr: got %0b expected 0111", predGhr);
        end
        tick();
    endtask

    task automatic test_same_index();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        total++;
        if (predTaken !== 1'b0) begin
            bad++; $display("[TB] FAIL same_idx_now: got %0b expected 0", predTaken);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (predTaken !== 1'b1) begin
            bad++; $display("[TB] FAIL same_idx_next: got %0b expected 1", predTaken);
        end
        tick();
    endtask

    task automatic test_stats_and_midreset();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h30, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (statBrS !== 2'd3 || statMpS !== 2'd3) begin
            bad++; $display("[TB] FAIL stat_sat2: got %0d/%0d expected 3/3", statBrS, statMpS);
        end
        total++;
        if (statBr !== 32'd5 || statMp !== 32'd5) begin
            bad++; $display("[TB] FAIL stat_wide: got %0d/%0d expected 5/5", statBr, statMp);
        end
        tick();
        drive(1'b1, 32'h44, 1'b1, 32'h8, 4'h5, 1'b1, 1'b1, 1'b1);
        tick();
        for (int p = 0; p < 16; p++) begin
            drive(1'b0, 32'(p * 4), 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
            total++;
            if (predTaken !== 1'b0 || predGhr !== 4'h0) begin
                bad++; $display("[TB] FAIL midreset_entry%0d: got %0b/%0b expected 0/0000",
                                p, predTaken, predGhr);
            end
            if (p == 0) begin
                total++;
                if (statBr !== 32'd0 || statMp !== 32'd0 || statBrS !== 2'd0 || statMpS !== 2'd0) begin
                    bad++; $display("[TB] FAIL midreset_stats: got %0d/%0d/%0d/%0d expected all 0",
                                    statBr, statMp, statBrS, statMpS);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) == 0));
            total++;
            if (predTaken !== expPred() || predTakenS !== expPred()) begin
                bad++; $display("[TB] FAIL rand_pred@%0d: got %0b/%0b expected %0d",
                                n, predTaken, predTakenS, expPred());
            end
            total++;
            if (predGhr !== 4'(mGhr) || predGhrS !== 4'(mGhr)) begin
                bad++; $display("[TB] FAIL rand_ghr@%0d: got %0b/%0b expected %0b",
                                n, predGhr, predGhrS, 4'(mGhr));
            end
            total++;
            if (statBr !== 32'(mBr) || statMp !== 32'(mMp)) begin
                bad++; $display("[TB] FAIL rand_stats@%0d: got %0d/%0d expected %0d/%0d",
                                n, statBr, statMp, mBr, mMp);
            end
            total++;
            if (statBrS !== 2'(sat3(mBr)) || statMpS !== 2'(sat3(mMp))) begin
                bad++; $display("[TB] FAIL rand_stats2@%0d: got %0d/%0d expected %0d/%0d",
                                n, statBrS, statMpS, sat3(mBr), sat3(mMp));
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mdl[k] = 1;
        test_reset();
        test_train_saturate();
        test_history();
        test_recovery_priority();
        test_same_index();
        test_stats_and_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
